mem_arbiter: RTL and testbench

- Shares the single-port, fixed one-cycle-latency memory bus between the CPU core (master 0) and a secondary master (master 1), such as the debug/program loader or a DMA engine.
- The CPU has absolute priority, because the core has no stall input. The secondary master only gets the bus in cycles where the CPU leaves it idle.
- The block tracks ownership of each outstanding access, routes read data back to the owning master, and holds the last CPU read word so that secondary traffic cannot corrupt CPU load/fetch data.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port, one-cycle-latency memory bus between the CPU core
// (master 0, absolute priority, cannot stall) and a secondary master (master 1, e.g. a
// program loader or DMA engine) that only gets cycles the CPU leaves idle.
//
// Tracks which master owns the access in flight, routes read data back to it, and holds
// the last CPU read word so secondary traffic never disturbs CPU load/fetch data.
//
// Optional feature (compile-time macro ARB_STARVE_EN): starvation avoidance. After
// STARVE_MAX consecutive unserved secondary request cycles, cpu_hold_o freezes the CPU
// for one cycle and the secondary is granted. Without the macro the CPU always wins and
// cpu_hold_o is tied 0.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cpu_enable_i/wstrb/addr/wvalue  CPU access (wstrb 0 = read), cpu_rvalue_o read data
//   sec_req_i/wstrb/addr/wdata   secondary request, held stable until sec_gnt_o
//   sec_gnt_o                    secondary access issued this cycle
//   sec_rvalid_o, sec_rdata_o    secondary read data (one-cycle valid, data held after)
//   cpu_hold_o                   one-cycle CPU freeze request (ARB_STARVE_EN only)
//   mem_enable_o/wstrb/addr/wvalue  memory request, mem_rvalue_i read data one cycle later
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_enable_i,
  input  logic [3:0]  cpu_wstrb_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wvalue_i,
  output logic [31:0] cpu_rvalue_o,
  input  logic        sec_req_i,
  input  logic [3:0]  sec_wstrb_i,
  input  logic [31:0] sec_addr_i,
  input  logic [31:0] sec_wdata_i,
  output logic        sec_gnt_o,
  output logic        sec_rvalid_o,
  output logic [31:0] sec_rdata_o,
  output logic        cpu_hold_o,
  output logic        mem_enable_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wvalue_o,
  input  logic [31:0] mem_rvalue_i
);

  typedef enum logic [1:0] {OwnNone, OwnCpuRd, OwnSecRd} owner_e;

  owner_e      owner_q, owner_d;
  logic [31:0] cpu_rdata_q, sec_rdata_q;
  logic        cpu_win, sec_win, hold;

`ifdef ARB_STARVE_EN
  logic [7:0] starve_q, starve_d;

  // Counter never passes STARVE_MAX: reaching it forces a grant, which clears it.
  assign hold = ~rst_i & sec_req_i & (starve_q == 8'(STARVE_MAX));

  always_comb begin
    starve_d = 8'd0;
    if (sec_req_i && !sec_win) starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) starve_q <= 8'd0;
    else       starve_q <= starve_d;
  end
`else
  // STARVE_MAX only matters with starvation avoidance; referenced to keep it live.
  assign hold = 1'b0 & (STARVE_MAX == 0);
`endif

  // Reset gates both grants so requests are ignored while rst_i is high.
  assign cpu_win    = ~rst_i & cpu_enable_i & ~hold;
  assign sec_win    = ~rst_i & sec_req_i & ~cpu_win;
  assign sec_gnt_o  = sec_win;
  assign cpu_hold_o = hold;

  always_comb begin
    mem_enable_o = 1'b0;
    mem_wstrb_o  = 4'd0;
    mem_addr_o   = 32'd0;
    mem_wvalue_o = 32'd0;
    owner_d      = OwnNone;
    if (cpu_win) begin
      mem_enable_o = 1'b1;
      mem_wstrb_o  = cpu_wstrb_i;
      mem_addr_o   = cpu_addr_i;
      mem_wvalue_o = cpu_wvalue_i;
      if (cpu_wstrb_i == 4'd0) owner_d = OwnCpuRd;
    end else if (sec_win) begin
      mem_enable_o = 1'b1;
      mem_wstrb_o  = sec_wstrb_i;
      mem_addr_o   = sec_addr_i;
      mem_wvalue_o = sec_wdata_i;
      if (sec_wstrb_i == 4'd0) owner_d = OwnSecRd;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q     <= OwnNone;
      cpu_rdata_q <= 32'd0;
      sec_rdata_q <= 32'd0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OwnCpuRd) cpu_rdata_q <= mem_rvalue_i;
      if (owner_q == OwnSecRd) sec_rdata_q <= mem_rvalue_i;
    end
  end

  // Read data is live from memory in the completion cycle, then held from the register.
  assign cpu_rvalue_o = (owner_q == OwnCpuRd) ? mem_rvalue_i : cpu_rdata_q;
  assign sec_rvalid_o = (owner_q == OwnSecRd);
  assign sec_rdata_o  = (owner_q == OwnSecRd) ? mem_rvalue_i : sec_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mem_arbiter;
  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_ws = 4'd0;
  logic [31:0] cpu_a = 32'd0, cpu_v = 32'd0;
  logic        sreq = 1'b0;
  logic [3:0]  sws = 4'd0;
  logic [31:0] sa = 32'd0, sd = 32'd0;
  logic [31:0] mr = 32'd0;
  logic [31:0] cpu_rvalue, sec_rdata, mem_addr, mem_wvalue;
  logic [3:0]  mem_wstrb;
  logic        sec_gnt, sec_rvalid, cpu_hold, mem_enable;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_enable_i(cpu_en), .cpu_wstrb_i(cpu_ws), .cpu_addr_i(cpu_a), .cpu_wvalue_i(cpu_v),
    .cpu_rvalue_o(cpu_rvalue),
    .sec_req_i(sreq), .sec_wstrb_i(sws), .sec_addr_i(sa), .sec_wdata_i(sd),
    .sec_gnt_o(sec_gnt), .sec_rvalid_o(sec_rvalid), .sec_rdata_o(sec_rdata),
    .cpu_hold_o(cpu_hold),
    .mem_enable_o(mem_enable), .mem_wstrb_o(mem_wstrb), .mem_addr_o(mem_addr),
    .mem_wvalue_o(mem_wvalue), .mem_rvalue_i(mr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what was issued last cycle (0 none, 1 CPU read, 2 secondary read),
  // the last word each master has received, and how long the secondary has been waiting.
  int          last_kind = 0;
  logic [31:0] cpu_word = 32'd0, sec_word = 32'd0;
  int unsigned wait_cnt = 0;
  bit          model_gnt = 1'b0;

  always @(negedge clk) begin
    bit          e_hold, e_cpu, e_gnt;
    logic [31:0] e_addr, e_wv, e_crv, e_srd;
    logic [3:0]  e_ws;
    if (rst) begin
      chk("m_rst_cpu_rvalue", cpu_rvalue, 32'd0);
      chk("m_rst_sec_rdata", sec_rdata, 32'd0);
      chk("m_rst_sec_rvalid", 32'(sec_rvalid), 32'd0);
      chk("m_rst_sec_gnt", 32'(sec_gnt), 32'd0);
      chk("m_rst_cpu_hold", 32'(cpu_hold), 32'd0);
      chk("m_rst_mem_en", 32'(mem_enable), 32'd0);
      chk("m_rst_mem_addr", mem_addr, 32'd0);
      last_kind = 0;
      cpu_word  = 32'd0;
      sec_word  = 32'd0;
      wait_cnt  = 0;
      model_gnt = 1'b0;
    end else begin
`ifdef ARB_STARVE_EN
      e_hold = sreq && (wait_cnt == SMAX);
`else
      e_hold = 1'b0;
`endif
      e_cpu = cpu_en && !e_hold;
      e_gnt = sreq && !e_cpu;
      e_addr = e_cpu ? cpu_a : (e_gnt ? sa : 32'd0);
      e_wv   = e_cpu ? cpu_v : (e_gnt ? sd : 32'd0);
      e_ws   = e_cpu ? cpu_ws : (e_gnt ? sws : 4'd0);
      e_crv  = (last_kind == 1) ? mr : cpu_word;
      e_srd  = (last_kind == 2) ? mr : sec_word;
      chk("m_cpu_rvalue", cpu_rvalue, e_crv);
      chk("m_sec_rdata", sec_rdata, e_srd);
      chk("m_sec_rvalid", 32'(sec_rvalid), 32'(last_kind == 2));
      chk("m_sec_gnt", 32'(sec_gnt), 32'(e_gnt));
      chk("m_cpu_hold", 32'(cpu_hold), 32'(e_hold));
      chk("m_mem_en", 32'(mem_enable), 32'(e_cpu || e_gnt));
      chk("m_mem_wstrb", 32'(mem_wstrb), 32'(e_ws));
      chk("m_mem_addr", mem_addr, e_addr);
      chk("m_mem_wvalue", mem_wvalue, e_wv);
      // Advance the model across the coming clock edge.
      if (last_kind == 1) cpu_word = mr;
      if (last_kind == 2) sec_word = mr;
      if (e_cpu && cpu_ws == 4'd0)      last_kind = 1;
      else if (e_gnt && sws == 4'd0)    last_kind = 2;
      else                              last_kind = 0;
      wait_cnt  = (sreq && !e_gnt) ? wait_cnt + 1 : 0;
      model_gnt = e_gnt;
    end
  end

  // Apply one cycle of stimulus just after the rising edge; returns with outputs settled.
  task automatic drive(input bit r, input bit ce, input logic [3:0] cw, input logic [31:0] ca,
                       input logic [31:0] cv, input bit s, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    @(posedge clk);
    #1;
    rst = r; cpu_en = ce; cpu_ws = cw; cpu_a = ca; cpu_v = cv;
    sreq = s; sws = w; sa = a; sd = d; mr = m;
    #2;
  endtask

  task automatic idle(input logic [31:0] m);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, m);
  endtask

  initial begin
    // Reset with both masters requesting: everything must stay quiet.
    rst = 1'b1; cpu_en = 1'b1; cpu_a = 32'h55; sreq = 1'b1; sa = 32'h66;
    #3;
    chk("rst_mem_en", 32'(mem_enable), 32'd0);
    chk("rst_sec_gnt", 32'(sec_gnt), 32'd0);
    chk("rst_cpu_rvalue", cpu_rvalue, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    drive(1'b1, 1'b1, 4'd0, 32'h55, 32'd0, 1'b1, 4'd0, 32'h66, 32'd0, 32'd0);
    idle(32'd0);

    // CPU read, then secondary read must not disturb the CPU word.
    drive(1'b0, 1'b1, 4'd0, 32'h10, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    chk("a_mem_addr", mem_addr, 32'h10);
    chk("a_mem_en", 32'(mem_enable), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h20, 32'd0, 32'hDEADBEEF);
    chk("a_cpu_rvalue", cpu_rvalue, 32'hDEADBEEF);
    chk("a_sec_gnt", 32'(sec_gnt), 32'd1);
    chk("a_sec_addr", mem_addr, 32'h20);
    idle(32'h12345678);
    chk("a_cpu_hold_word", cpu_rvalue, 32'hDEADBEEF);
    chk("a_sec_rvalid", 32'(sec_rvalid), 32'd1);
    chk("a_sec_rdata", sec_rdata, 32'h12345678);
    idle(32'hFFFF0000);
    chk("a_sec_rvalid_off", 32'(sec_rvalid), 32'd0);
    chk("a_sec_rdata_held", sec_rdata, 32'h12345678);
    chk("a_cpu_word_held", cpu_rvalue, 32'hDEADBEEF);

    // Conflict: CPU wins three cycles, secondary on the fourth.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, k < 4, 4'd0, 32'h100, 32'd0, 1'b1, 4'd0, 32'h200, 32'd0, 32'd0);
      chk("c_sec_gnt", 32'(sec_gnt), (k < 4) ? 32'd0 : 32'd1);
      chk("c_mem_addr", mem_addr, (k < 4) ? 32'h100 : 32'h200);
    end
    idle(32'd0);

    // Secondary write: forwarded, no rvalid.
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0011, 32'h40, 32'hCAFEF00D, 32'd0);
    chk("w_mem_en", 32'(mem_enable), 32'd1);
    chk("w_mem_wstrb", 32'(mem_wstrb), 32'h3);
    chk("w_mem_wvalue", mem_wvalue, 32'hCAFEF00D);
    chk("w_sec_gnt", 32'(sec_gnt), 32'd1);
    idle(32'd0);
    chk("w_no_rvalid", 32'(sec_rvalid), 32'd0);

    // Back-to-back secondary reads.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, k < 3, 4'd0, 32'(4 * k), 32'd0,
            32'hA0 + 32'(4 * (k - 1)));
      if (k < 3) chk("b_sec_gnt", 32'(sec_gnt), 32'd1);
      if (k > 0) begin
        chk("b_sec_rvalid", 32'(sec_rvalid), 32'd1);
        chk("b_sec_rdata", sec_rdata, 32'hA0 + 32'(4 * (k - 1)));
      end
    end
    idle(32'd0);
    chk("b_rvalid_end", 32'(sec_rvalid), 32'd0);

    // Reset while a secondary read is in flight.
    drive(1'b0, 1'b1, 4'd0, 32'h60, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h20, 32'd0, 32'h77777777);
    chk("r_cpu_word", cpu_rvalue, 32'h77777777);
    drive(1'b1, 1'b1, 4'd0, 32'h64, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'hABCDABCD);
    chk("r_rvalid", 32'(sec_rvalid), 32'd0);
    chk("r_sec_rdata", sec_rdata, 32'd0);
    chk("r_cpu_rvalue", cpu_rvalue, 32'd0);
    chk("r_mem_en", 32'(mem_enable), 32'd0);
    idle(32'h11111111);
    chk("r_rvalid_after", 32'(sec_rvalid), 32'd0);
    chk("r_cpu_after", cpu_rvalue, 32'd0);
    idle(32'd0);
    chk("r_rvalid_after2", 32'(sec_rvalid), 32'd0);

`ifdef ARB_STARVE_EN
    // CPU hogs the bus: forced grant on the 5th request cycle, and again after restart.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b1, 4'd0, 32'h300, 32'd0, 1'b1, 4'd0, (k <= 5) ? 32'h400 : 32'h500,
            32'd0, 32'd0);
      chk("s_cpu_hold", 32'(cpu_hold), (k == 5 || k == 10) ? 32'd1 : 32'd0);
      chk("s_sec_gnt", 32'(sec_gnt), (k == 5 || k == 10) ? 32'd1 : 32'd0);
      chk("s_mem_addr", mem_addr, (k == 5) ? 32'h400 : ((k == 10) ? 32'h500 : 32'h300));
    end
    idle(32'd0);
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst    = ($urandom_range(0, 299) == 0);
      cpu_en = ((i % 64) < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      cpu_ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      cpu_a  = $urandom;
      cpu_v  = $urandom;
      mr     = $urandom;
      if (!(sreq && !model_gnt)) begin
        sreq = ($urandom_range(0, 9) < 6);
        sws  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        sa   = $urandom;
        sd   = $urandom;
      end
    end
    idle(32'd0);
    idle(32'd0);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
